// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// SRAM-like bus (req/addr_ok/data_ok). One instance per port.
// The master modport issues requests and the slave modport answers them.
interface ysyx_22050710_sram_arbiter_if #(
  parameter int WORD_WD      = 64,
  parameter int SRAM_DATA_WD = 64
);
  logic                      req;
  logic                      wr;
  logic [2:0]                size;
  logic [SRAM_DATA_WD/8-1:0] wstrb;
  logic [WORD_WD-1:0]        addr;
  logic [SRAM_DATA_WD-1:0]   wdata;
  logic                      addr_ok;
  logic                      data_ok;
  logic [SRAM_DATA_WD-1:0]   rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-master (fetch, LSU) to one-slave SRAM-bus arbiter.
// Requests are granted data-first, and an in-order owner FIFO steers the responses back to the right master.
module ysyx_22050710_sram_arbiter #(
  parameter int WORD_WD         = 64,
  parameter int SRAM_DATA_WD    = 64,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  ysyx_22050710_sram_arbiter_if.slave   inst_if,
  ysyx_22050710_sram_arbiter_if.slave   data_if,
  ysyx_22050710_sram_arbiter_if.master  mem_if
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [SW-1:0] STV_MAX  = SW'(STARVE_LIMIT);

  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [SW-1:0]              starve_q, starve_d;

  logic full, starved, grant_data, grant_inst, fire, pop, head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Grant looks only at the registered count, so no path runs from i_data_ok to o_req.
  assign full       = (cnt_q == CNT_MAX);
  assign starved    = inst_if.req && (starve_q == STV_MAX);
  assign grant_data = !i_rst && !full && data_if.req && !starved;
  assign grant_inst = !i_rst && !full && inst_if.req && !grant_data;
  assign fire       = (grant_data || grant_inst) && mem_if.addr_ok;
  assign pop        = mem_if.data_ok && (cnt_q != '0);
  assign head_data  = owner_q[rd_ptr_q];

  assign mem_if.req   = grant_data || grant_inst;
  assign mem_if.wr    = grant_data && data_if.wr;
  assign mem_if.size  = grant_data ? data_if.size  : (grant_inst ? 3'd2 : 3'd0);
  assign mem_if.wstrb = grant_data ? data_if.wstrb : '0;
  assign mem_if.addr  = grant_data ? data_if.addr  : (grant_inst ? inst_if.addr : '0);
  assign mem_if.wdata = grant_data ? data_if.wdata : '0;

  assign data_if.addr_ok = grant_data && mem_if.addr_ok;
  assign inst_if.addr_ok = grant_inst && mem_if.addr_ok;
  assign data_if.data_ok = pop && head_data;
  assign inst_if.data_ok = pop && !head_data;
  assign data_if.rdata   = (pop && head_data)  ? mem_if.rdata : '0;
  assign inst_if.rdata   = (pop && !head_data) ? mem_if.rdata : '0;

  // The fetch port is read-only and always issues words, so its payload fields are not used.
  logic unused_inst_payload;
  assign unused_inst_payload = ^{inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.wdata};

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    if (fire) begin
      owner_d[wr_ptr_q] = grant_data;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({fire, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (!inst_if.req || (grant_inst && mem_if.addr_ok))
      starve_d = '0;
    else if (grant_data && mem_if.addr_ok && (starve_q != STV_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end
endmodule
